// File: rtl/hgo_pkg.sv
// hgo_pkg: shared definitions for the multi-channel PUF run sequencer.
//   state_t        sequencer state encoding
//   STAT_*         bit positions inside o_stat
//   NCH_MAX        largest supported channel count
//   CNT_MAX        saturation value of the capture counter
package hgo_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CAPT,
        S_HOLD,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam int STAT_TOUT_LSB = 0;
    localparam int STAT_CNT_LSB  = 8;
    localparam int STAT_EMPTY    = 15;
    localparam int NCH_MAX       = 8;
    localparam logic [6:0] CNT_MAX = 7'd127;

endpackage

// File: rtl/hgo_next_ch.sv
// hgo_next_ch: combinational finder for the next enabled channel.
//   mask  in   NCH  channel enable bits
//   idx   in   3    reference channel index
//   incl  in   1    1: idx itself may be returned; 0: only bits strictly above idx
//   nxt   out  3    lowest qualifying set bit
//   none  out  1    no qualifying bit exists (nxt is 0)
module hgo_next_ch
    import hgo_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] mask,
    input  logic [2:0]     idx,
    input  logic           incl,
    output logic [2:0]     nxt,
    output logic           none
);

    // Scan from the top down so the lowest qualifying bit is the last one written.
    always_comb begin
        nxt  = '0;
        none = 1'b1;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k] && ((k > int'(idx)) || (incl && (k == int'(idx))))) begin
                nxt  = 3'(k);
                none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/hgo_multi_seq.sv
// hgo_multi_seq: multi-channel PUF run sequencer between the JTAG test
// register file and NCH puf cores. A rising edge on i_go launches every
// enabled channel in ascending order, i_rpt+1 times each, captures each auth
// word and hands it to JTAG with a vld/ack handshake.
//
// Build option: define HGO_SEQ_TOUT_EN to build the per-launch timeout
// counter (i_tout, stat[7:0]). Without it WAIT waits indefinitely, i_tout is
// unused and stat[7:0] reads 0.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_go           run request level; rising edge starts a run when idle
//   i_ch_mask      channel enables        (latched at start)
//   i_rpt          repeats per channel - 1 (latched at start)
//   i_tout         timeout cycles, 0=none (latched at start)
//   o_ch_go        one-hot 1-cycle launch pulse
//   i_ch_done      per-channel completion
//   i_ch_auth      auth words, channel k at [k*AUTH_W +: AUTH_W]
//   o_auth/_ch/_vld captured word, its channel, valid (held until ack)
//   i_auth_ack     JTAG consumed the word
//   o_save         1-cycle pulse per capture
//   o_done         run complete (held until next accepted go)
//   o_busy         run in progress
//   o_stat         [7:0] timeout flags, [14:8] capture count (sat), [15] empty mask
module hgo_multi_seq
    import hgo_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int AUTH_W = 128,
    parameter int RPT_W  = 4,
    parameter int TOUT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_go,
    input  logic [NCH-1:0]        i_ch_mask,
    input  logic [RPT_W-1:0]      i_rpt,
    input  logic [TOUT_W-1:0]     i_tout,
    output logic [NCH-1:0]        o_ch_go,
    input  logic [NCH-1:0]        i_ch_done,
    input  logic [NCH*AUTH_W-1:0] i_ch_auth,
    output logic [AUTH_W-1:0]     o_auth,
    output logic [2:0]            o_auth_ch,
    output logic                  o_auth_vld,
    input  logic                  i_auth_ack,
    output logic                  o_save,
    output logic                  o_done,
    output logic                  o_busy,
    output logic [15:0]           o_stat
);

    state_t               state;
    logic                 go_q;
    logic [NCH-1:0]       mask_q;
    logic [RPT_W-1:0]     rpt_q;
    logic [RPT_W-1:0]     rpt_left;
    logic [2:0]           ch;
    logic [NCH_MAX-1:0]   tout_flags;
    logic [6:0]           cap_cnt;
    logic                 empty_q;
    logic                 tout_hit;

    logic                 go_edge;
    logic                 done_sel;
    logic [AUTH_W-1:0]    auth_sel;
    logic [NCH-1:0]       ch_onehot;
    logic [NCH-1:0]       find_mask;
    logic [2:0]           nxt;
    logic                 nxt_none;

    assign go_edge = i_go & ~go_q;

    // In IDLE the finder looks at the live mask (lowest bit, inclusive);
    // in NEXT it looks above the current channel in the latched mask.
    assign find_mask = (state == S_IDLE) ? i_ch_mask : mask_q;

    hgo_next_ch #(.NCH(NCH)) u_next_ch (
        .mask (find_mask),
        .idx  ((state == S_IDLE) ? 3'd0 : ch),
        .incl (state == S_IDLE),
        .nxt  (nxt),
        .none (nxt_none)
    );

    // Per-channel selection by loop keeps index widths exact for any NCH.
    always_comb begin
        done_sel  = 1'b0;
        auth_sel  = '0;
        ch_onehot = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(ch) == k) begin
                done_sel     = i_ch_done[k];
                auth_sel     = i_ch_auth[k*AUTH_W +: AUTH_W];
                ch_onehot[k] = 1'b1;
            end
        end
    end

`ifdef HGO_SEQ_TOUT_EN
    logic [TOUT_W-1:0] tout_q;
    logic [TOUT_W-1:0] tcnt;

    assign tout_hit = (tout_q != '0) && (tcnt == tout_q - TOUT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tout_q <= '0;
            tcnt   <= '0;
        end else begin
            if ((state == S_IDLE) && go_edge)
                tout_q <= i_tout;
            if (state == S_LAUNCH)
                tcnt <= '0;
            else if (state == S_WAIT)
                tcnt <= tcnt + TOUT_W'(1);
        end
    end
`else
    logic unused_tout;
    assign unused_tout = ^i_tout;
    assign tout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            go_q       <= 1'b1;   // a go held through reset must not look like an edge
            mask_q     <= '0;
            rpt_q      <= '0;
            rpt_left   <= '0;
            ch         <= '0;
            tout_flags <= '0;
            cap_cnt    <= '0;
            empty_q    <= 1'b0;
            o_ch_go    <= '0;
            o_auth     <= '0;
            o_auth_ch  <= '0;
            o_auth_vld <= 1'b0;
            o_save     <= 1'b0;
            o_done     <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            go_q    <= i_go;
            o_ch_go <= '0;
            o_save  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go_edge) begin
                        mask_q     <= i_ch_mask;
                        rpt_q      <= i_rpt;
                        rpt_left   <= i_rpt;
                        tout_flags <= '0;
                        cap_cnt    <= '0;
                        empty_q    <= 1'b0;
                        o_done     <= 1'b0;
                        o_busy     <= 1'b1;
                        if (i_ch_mask == '0) begin
                            empty_q <= 1'b1;
                            state   <= S_FINISH;
                        end else begin
                            ch    <= nxt;
                            state <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    o_ch_go <= ch_onehot;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // done takes priority over a timeout in the same cycle
                    if (done_sel) begin
                        state <= S_CAPT;
                    end else if (tout_hit) begin
                        tout_flags[ch] <= 1'b1;
                        state          <= S_NEXT;
                    end
                end
                S_CAPT: begin
                    o_auth     <= auth_sel;
                    o_auth_ch  <= ch;
                    o_auth_vld <= 1'b1;
                    o_save     <= 1'b1;
                    if (cap_cnt != CNT_MAX)
                        cap_cnt <= cap_cnt + 7'd1;
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (i_auth_ack) begin
                        o_auth_vld <= 1'b0;
                        state      <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (rpt_left != '0) begin
                        rpt_left <= rpt_left - RPT_W'(1);
                        state    <= S_LAUNCH;
                    end else if (nxt_none) begin
                        state <= S_FINISH;
                    end else begin
                        ch       <= nxt;
                        rpt_left <= rpt_q;
                        state    <= S_LAUNCH;
                    end
                end
                S_FINISH: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_stat = '0;
        o_stat[STAT_TOUT_LSB +: NCH_MAX] = tout_flags;
        o_stat[STAT_CNT_LSB +: 7]        = cap_cnt;
        o_stat[STAT_EMPTY]               = empty_q;
    end

endmodule

// File: tb/tb_hgo_multi_seq.sv
// Testbench for hgo_multi_seq (8 channels). Directed runs with a behavioural
// model of the launch order and final status, a puf responder, a JTAG acker
// and one per-cycle compare process.
module tb_hgo_multi_seq;

    localparam int NCH    = 8;
    localparam int AUTH_W = 128;
`ifdef HGO_SEQ_TOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  i_go = 1'b0;
    logic [NCH-1:0]        i_ch_mask = '0;
    logic [3:0]            i_rpt = '0;
    logic [15:0]           i_tout = '0;
    logic [NCH-1:0]        o_ch_go;
    logic [NCH-1:0]        i_ch_done = '0;
    logic [NCH*AUTH_W-1:0] i_ch_auth = '0;
    logic [AUTH_W-1:0]     o_auth;
    logic [2:0]            o_auth_ch;
    logic                  o_auth_vld;
    logic                  i_auth_ack = 1'b0;
    logic                  o_save;
    logic                  o_done;
    logic                  o_busy;
    logic [15:0]           o_stat;

    hgo_multi_seq #(.NCH(NCH), .AUTH_W(AUTH_W), .RPT_W(4), .TOUT_W(16)) dut (
        .clk(clk), .rst(rst), .i_go(i_go), .i_ch_mask(i_ch_mask), .i_rpt(i_rpt),
        .i_tout(i_tout), .o_ch_go(o_ch_go), .i_ch_done(i_ch_done), .i_ch_auth(i_ch_auth),
        .o_auth(o_auth), .o_auth_ch(o_auth_ch), .o_auth_vld(o_auth_vld),
        .i_auth_ack(i_auth_ack), .o_save(o_save), .o_done(o_done), .o_busy(o_busy),
        .o_stat(o_stat)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Environment state
    int             puf_dly [NCH];
    bit             dead    [NCH];
    int             cd      [NCH];
    logic [127:0]   auth_w  [NCH];
    int             seq_no = 0;
    int             ack_dly = 0;
    logic [NCH-1:0] stray = '0;
    bit             chk_en = 1'b0;

    // Model queues
    int             exp_launch[$];
    int             cap_ch_q[$];
    logic [127:0]   cap_a_q[$];

    // PUF responder: done pulse puf_dly cycles after its launch, with a fresh word.
    initial begin
        for (int k = 0; k < NCH; k++) begin
            cd[k] = -1; puf_dly[k] = 10; dead[k] = 1'b0; auth_w[k] = '0;
        end
        forever begin
            @(negedge clk);
            i_ch_done = stray;
            stray = '0;
            for (int k = 0; k < NCH; k++) begin
                if (cd[k] > 0) begin
                    cd[k]--;
                    if (cd[k] == 0) begin
                        seq_no++;
                        auth_w[k] = {32'(seq_no), 32'(k), ~32'(seq_no), 32'(seq_no) ^ 32'hC0FFEE00};
                        i_ch_auth[k*AUTH_W +: AUTH_W] = auth_w[k];
                        i_ch_done[k] = 1'b1;
                        cap_ch_q.push_back(k);
                        cap_a_q.push_back(auth_w[k]);
                        cd[k] = -1;
                    end
                end
            end
            for (int k = 0; k < NCH; k++)
                if (o_ch_go[k] && !dead[k]) cd[k] = puf_dly[k];
        end
    end

    // JTAG acker: ack after o_auth_vld has been seen ack_dly+1 times.
    int hold_cnt = 0;
    initial forever begin
        @(negedge clk);
        i_auth_ack = 1'b0;
        if (o_auth_vld) begin
            hold_cnt++;
            if (hold_cnt > ack_dly) begin
                i_auth_ack = 1'b1;
                hold_cnt = 0;
            end
        end else begin
            hold_cnt = 0;
        end
    end

    // Per-cycle compare process
    int           cmp_c;
    logic [7:0]   cmp_oh;
    logic [127:0] held_auth = '0;
    logic [2:0]   held_ch = '0;
    initial forever begin
        @(negedge clk);
        if (chk_en && !rst) begin
            if (o_ch_go != '0) begin
                if (exp_launch.size() == 0) begin
                    chk("unexpected_launch", o_ch_go, 0);
                end else begin
                    cmp_c  = exp_launch.pop_front();
                    cmp_oh = 8'b1 << cmp_c;
                    chk("launch_onehot", o_ch_go, cmp_oh);
                end
            end
            if (o_save) begin
                if (cap_ch_q.size() == 0) begin
                    chk("unexpected_save", o_save, 0);
                end else begin
                    held_ch   = 3'(cap_ch_q.pop_front());
                    held_auth = cap_a_q.pop_front();
                    chk("cap_ch", o_auth_ch, held_ch);
                    chk("cap_auth", o_auth, held_auth);
                    chk("cap_vld", o_auth_vld, 1);
                end
            end else if (o_auth_vld) begin
                chk("hold_auth", o_auth, held_auth);
                chk("hold_ch", o_auth_ch, held_ch);
                chk("hold_no_launch", o_ch_go, 0);
            end
        end
    end

    // One run: model the expected launches and status, apply go, wait for done.
    task automatic run(input logic [7:0] m, input logic [3:0] r, input logic [15:0] t,
                       input int disturb, input logic [7:0] stray_m, input logic [15:0] lit_stat);
        int         n_ok = 0;
        logic [7:0] flags = '0;
        logic [6:0] cnt;
        logic [15:0] exp_stat;
        int         lat = 0;
        int         done_at = 0;
        for (int k = 0; k < NCH; k++) begin
            if (m[k]) begin
                for (int j = 0; j <= int'(r); j++) exp_launch.push_back(k);
                if (TOUT_EN && t != 0 && dead[k]) flags[k] = 1'b1;
                else n_ok += int'(r) + 1;
            end
        end
        cnt = (n_ok > 127) ? 7'd127 : 7'(n_ok);
        exp_stat = {(m == 0), cnt, flags};

        @(negedge clk);
        i_ch_mask = m; i_rpt = r; i_tout = t; i_go = 1'b1;
        for (int c = 1; c <= 5000; c++) begin
            @(negedge clk);
            if (lat == 0 && o_ch_go != '0) lat = c;
            if (c == disturb) begin
                i_go = 1'b0; i_ch_mask = ~m; i_rpt = ~r; i_tout = 16'd1;
            end
            if (c == disturb + 1) begin
                i_go = 1'b1; stray = stray_m;
            end
            if (o_done) begin
                done_at = c;
                break;
            end
        end
        chk("done_reached", (done_at > 0), 1);
        chk("busy_after_done", o_busy, 0);
        i_go = 1'b0; i_ch_mask = m; i_rpt = r; i_tout = t;
        @(negedge clk);
        chk("done_held", o_done, 1);
        chk("stat_model", o_stat, exp_stat);
        chk("stat_literal", o_stat, lit_stat);
        chk("launches_left", exp_launch.size(), 0);
        chk("captures_left", cap_ch_q.size(), 0);
        if (m != 0) begin
            chk("go_latency", lat, 2);
        end else begin
            chk("empty_done_latency", done_at, 2);
            chk("empty_no_launch", lat, 0);
        end
    endtask

    int bad;

    initial begin
        // Reset with go held high: all outputs 0, and no run starts afterwards.
        i_go = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {o_ch_go, o_auth, o_auth_ch, o_auth_vld, o_save, o_done, o_busy, o_stat}, 0);
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("go_through_reset_idle", o_busy, 0);
        i_go = 1'b0;
        @(negedge clk);

        // Two channels, two launches each
        for (int k = 0; k < NCH; k++) puf_dly[k] = 10;
        run(8'h05, 4'd1, 16'd0, 0, 8'h00, 16'h0400);

        // Empty mask
        run(8'h00, 4'd0, 16'd0, 0, 8'h00, 16'h8000);

`ifdef HGO_SEQ_TOUT_EN
        // ch0 done on the timeout cycle (done wins), ch1 silent (times out), ch2 normal
        puf_dly[0] = 7; dead[1] = 1'b1; puf_dly[2] = 3;
        run(8'h07, 4'd0, 16'd8, 0, 8'h00, 16'h0202);
        dead[1] = 1'b0;
        for (int k = 0; k < NCH; k++) puf_dly[k] = 10;
`else
        // i_tout has no effect without the timeout build
        puf_dly[0] = 5;
        run(8'h01, 4'd0, 16'd2, 0, 8'h00, 16'h0100);
        puf_dly[0] = 10;
`endif

        // JTAG slow to ack: word held stable, no launch until ack
        ack_dly = 50;
        run(8'h08, 4'd1, 16'd0, 0, 8'h00, 16'h0200);
        ack_dly = 0;

        // Go edge while busy, stray done on unselected ch0, input changes mid-run
        run(8'h12, 4'd2, 16'd0, 5, 8'h01, 16'h0600);

        // 128 captures: count saturates at 127
        for (int k = 0; k < NCH; k++) puf_dly[k] = 1;
        run(8'hFF, 4'd15, 16'd0, 0, 8'h00, 16'h7F00);
        for (int k = 0; k < NCH; k++) puf_dly[k] = 10;

        // Reset during WAIT with go held high
        chk_en = 1'b0;
        puf_dly[0] = 30;
        @(negedge clk);
        i_ch_mask = 8'h01; i_rpt = 4'd0; i_tout = 16'd0; i_go = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_rst_outputs", {o_ch_go, o_auth, o_auth_ch, o_auth_vld, o_save, o_done, o_busy, o_stat}, 0);
        rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_ch_go != '0 || o_save || o_busy || o_done) bad++;
        end
        chk("no_restart_after_rst", bad, 0);
        i_go = 1'b0;
        for (int k = 0; k < NCH; k++) cd[k] = -1;
        exp_launch.delete(); cap_ch_q.delete(); cap_a_q.delete();
        puf_dly[0] = 10;
        chk_en = 1'b1;

        // Normal run after the abort
        run(8'h01, 4'd0, 16'd0, 0, 8'h00, 16'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
